quant_pack8: RTL and testbench
==============================

# quant_pack8

Downstream stage of the uint8 re-quantizer. It collects the serial stream of requantized uint8 activations into 64-bit words and buffers them in a small FIFO. Words leave through a valid/ready handshake toward the output SRAM writer. Partial words at tile ends are flushed with a byte-keep mask. A sticky overflow flag is raised when the requantizer pushes into a full buffer, because the requantizer cannot be stalled directly.

## Interface
- `FIFO_DEPTH`, 4: word FIFO entries; power of two, ≥2.
- `AF_LEVEL`, 3: `almost_full` threshold, in words.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `valid_in`  in  1  one uint8 result present this cycle (requantizer output valid).
- `uint8_in`  in  8  requantized activation.
- `last_in`  in  1  qualifies `valid_in`; this byte ends the current tile/channel group.
- `out_valid`  out  1  FIFO head word available.
- `out_ready`  in  1  consumer accepts the head word this cycle.
- `out_data`  out  64  packed word; first byte of the word in `[7:0]`, eighth byte in `[63:56]`.
- `out_keep`  out  8  byte-lane valid mask for `out_data`.
- `out_last`  out  1  word contains the byte that carried `last_in`.
- `almost_full`  out  1  FIFO count ≥ `AF_LEVEL`; the controller uses it to pause the requantizer.
- `fifo_cnt`  out  `$clog2(FIFO_DEPTH)+1`  current FIFO occupancy.
- `ovf_err`  out  1  sticky: a completed word was dropped because the FIFO was full.

## Operation
- Packer: 64-bit shift/lane register plus a 3-bit lane pointer `lp`.
- Each `valid_in` byte is written into lane `lp`, and `lp` increments.
- Word completion occurs when the byte lands in lane 7, or when `last_in`=1.
- On completion, the word, its keep mask and the last bit are latched into a one-entry staging register (`stg_vld`=1), and `lp` returns to 0 in the same edge.
  - Keep mask: `lp+1` low bits set.
  - Unused lanes are padded (see Configuration).
- Push: `stg_vld` is written into the FIFO on the next edge if `fifo_cnt < FIFO_DEPTH` or a pop occurs in the same cycle.
  - Otherwise the staged word is discarded, `ovf_err` is set, and `stg_vld` clears.
  - The staging register never stalls the packer.
- Pop: `out_valid && out_ready`. The head advances, and `out_data`/`out_keep`/`out_last` show the new head in the next cycle.
- FIFO outputs are first-word-fall-through: `out_data`/`out_keep`/`out_last` are stable whenever `out_valid`=1 and `out_ready`=0.
- Simultaneous push and pop: occupancy is unchanged, and both take effect.
- Read/write pointers wrap modulo `FIFO_DEPTH`.
- A `last_in` byte that lands in lane 7 produces a single word with keep=`8'hFF` and `out_last`=1; no extra empty word is generated.
- `ovf_err` clears only on `reset`.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_keep`=0, `out_last`=0.
  - `almost_full`=0, `fifo_cnt`=0, `ovf_err`=0.
  - `lp`=0, `stg_vld`=0; FIFO pointers 0.
- Latency: the completing byte is sampled at edge k. The word is staged at k and pushed at k+1, so `out_valid`=1 in the cycle after edge k+1, i.e. 2 cycles.
- Throughput: one byte per cycle sustained, and one word pop per cycle.
- `almost_full` and `fifo_cnt` are registered and reflect occupancy after the current edge.
- Reset mid-operation: a partially packed word, the staged word and all FIFO contents are discarded. `out_valid` drops in the cycle after the reset edge.
- `valid_in`=0 cycles leave `lp` and the packer contents unchanged; there is no timeout flush.

## Configuration
- `QPACK_PAD_Z3_EN`
  - Defined: adds input port `z3` (8-bit, the output zero-point), and unused lanes of a partial word are filled with `z3`.
  - Undefined: no `z3` port, and unused lanes are filled with `8'h00`.
  - `out_keep` behaves identically in both builds.

## Test plan
- Stream bytes `0x01..0x10`, `out_ready`=1 → two words: `0x0807060504030201` and `0x100F0E0D0C0B0A09`, each with keep=`FF` and last=0. The first `out_valid` appears 2 cycles after the byte `0x08` is sampled.
- 3 bytes `A1,A2,A3` with `last_in` on `A3` → `out_data=0x0000000000A3A2A1` (or with `z3`=`0x80` and the macro defined: `0x808080808080A3A2A1` truncated to 64 bits, i.e. upper 5 lanes `0x80`), keep=`07`, last=1.
- `out_ready`=0, push 4 words (`fifo_cnt`=4, `almost_full`=1 from count 3), then a 5th word → word dropped and `ovf_err`=1. Releasing `out_ready` pops exactly the first 4 words in order, and `ovf_err` stays 1.
- FIFO full, 5th word staged in the same cycle as a pop → no drop, `ovf_err`=0, and `fifo_cnt` stays 4.
- Assert `reset` after 5 bytes of a word with 2 words queued → next cycle `out_valid`=0 and `fifo_cnt`=0. Then 8 new bytes produce one clean word with keep=`FF`.
- `last_in` on the 8th byte → a single word with keep=`FF`, last=1, and no trailing empty word.

Source files
------------

// File: rtl/quant_pack8.sv
// rtl/quant_pack8.sv - uint8 activation packer into 64-bit words with word FIFO and overflow flag
// Build option: define QPACK_PAD_Z3_EN to add the z3 port and pad unused lanes with z3 instead of 8'h00.
module quant_pack8 #(
   parameter int FIFO_DEPTH = 4,
   parameter int AF_LEVEL   = 3
) (
   input  logic                          clk,
   input  logic                          reset,
`ifdef QPACK_PAD_Z3_EN
   input  logic [7:0]                    z3,
`endif
   input  logic                          valid_in,
   input  logic [7:0]                    uint8_in,
   input  logic                          last_in,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [63:0]                   out_data,
   output logic [7:0]                    out_keep,
   output logic                          out_last,
   output logic                          almost_full,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
   output logic                          ovf_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

   logic [7:0]    pad_byte;
   logic [63:0]   pk_data;
   logic [2:0]    lp;
   logic [63:0]   word_nxt;
   logic [7:0]    keep_nxt;
   logic          complete;

   logic          stg_vld;
   logic [63:0]   stg_data;
   logic [7:0]    stg_keep;
   logic          stg_last;

   logic [72:0]   mem [FIFO_DEPTH];
   logic [72:0]   head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;
   logic [CW-1:0] cnt_nxt;

`ifdef QPACK_PAD_Z3_EN
   assign pad_byte = z3;
`else
   assign pad_byte = 8'h00;
`endif

   // Word as it would look with the current byte in lane lp; lanes above lp carry padding.
   always_comb begin
      word_nxt = '0;
      keep_nxt = '0;
      for (int i = 0; i < 8; i++) begin
         if (3'(i) < lp) begin
            word_nxt[8*i +: 8] = pk_data[8*i +: 8];
            keep_nxt[i]        = 1'b1;
         end else if (3'(i) == lp) begin
            word_nxt[8*i +: 8] = uint8_in;
            keep_nxt[i]        = 1'b1;
         end else begin
            word_nxt[8*i +: 8] = pad_byte;
         end
      end
      complete = valid_in && ((lp == 3'd7) || last_in);
   end

   // Packer lanes and one-entry staging register; staging lives exactly one cycle so it never stalls.
   always_ff @(posedge clk) begin
      if (reset) begin
         pk_data  <= '0;
         lp       <= '0;
         stg_vld  <= 1'b0;
         stg_data <= '0;
         stg_keep <= '0;
         stg_last <= 1'b0;
      end else begin
         stg_vld <= complete;
         if (valid_in) begin
            pk_data <= word_nxt;
            if (complete) begin
               lp       <= '0;
               stg_data <= word_nxt;
               stg_keep <= keep_nxt;
               stg_last <= last_in;
            end else begin
               lp <= lp + 3'd1;
            end
         end
      end
   end

   assign out_valid = (fifo_cnt != '0);
   assign pop       = out_valid && out_ready;
   assign push      = stg_vld && ((fifo_cnt < DEPTH_C) || pop);

   // Occupancy after this edge; a push paired with a pop leaves it unchanged.
   always_comb begin
      cnt_nxt = fifo_cnt;
      if (push && !pop) cnt_nxt = fifo_cnt + CW'(1);
      else if (pop && !push) cnt_nxt = fifo_cnt - CW'(1);
   end

   // Word storage; contents need no reset because outputs are gated by out_valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {stg_last, stg_keep, stg_data};
   end

   // FIFO pointers, registered occupancy flags and the sticky drop flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_cnt    <= '0;
         almost_full <= 1'b0;
         ovf_err     <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         fifo_cnt    <= cnt_nxt;
         almost_full <= (cnt_nxt >= AF_C);
         if (stg_vld && !push) ovf_err <= 1'b1;
      end
   end

   assign head     = mem[rd_ptr];
   assign out_data = out_valid ? head[63:0]  : 64'h0;
   assign out_keep = out_valid ? head[71:64] : 8'h00;
   assign out_last = out_valid ? head[72]    : 1'b0;

endmodule

// File: tb/tb_quant_pack8.sv
// tb/tb_quant_pack8.sv - directed self-checking bench for quant_pack8
module tb_quant_pack8;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_in;
   logic [7:0]  uint8_in;
   logic        last_in;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic [7:0]  out_keep;
   logic        out_last;
   logic        almost_full;
   logic [2:0]  fifo_cnt;
   logic        ovf_err;

`ifdef QPACK_PAD_Z3_EN
   localparam logic [7:0] PAD = 8'h80;
   logic [7:0] z3 = PAD;
`else
   localparam logic [7:0] PAD = 8'h00;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   quant_pack8 #(.FIFO_DEPTH(4), .AF_LEVEL(3)) dut (
      .clk         (clk),
      .reset       (reset),
`ifdef QPACK_PAD_Z3_EN
      .z3          (z3),
`endif
      .valid_in    (valid_in),
      .uint8_in    (uint8_in),
      .last_in     (last_in),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_keep    (out_keep),
      .out_last    (out_last),
      .almost_full (almost_full),
      .fifo_cnt    (fifo_cnt),
      .ovf_err     (ovf_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic l);
      valid_in = 1'b1;
      uint8_in = b;
      last_in  = l;
      step();
      valid_in = 1'b0;
      last_in  = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; valid_in = 1'b0; uint8_in = '0; last_in = 1'b0; out_ready = 1'b0;
      step();
      step();
      reset = 1'b0;

      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_out_data", out_data, 64'h0);
      chk("rst_out_keep", 64'(out_keep), 64'h0);
      chk("rst_out_last", 64'(out_last), 64'h0);
      chk("rst_almost_full", 64'(almost_full), 64'h0);
      chk("rst_fifo_cnt", 64'(fifo_cnt), 64'h0);
      chk("rst_ovf_err", 64'(ovf_err), 64'h0);

      // Two full words streamed with the consumer always ready.
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
      chk("lat_staged_not_valid", 64'(out_valid), 64'h0);
      send_byte(8'h09, 1'b0);
      chk("w0_valid", 64'(out_valid), 64'h1);
      chk("w0_data", out_data, 64'h0807060504030201);
      chk("w0_keep", 64'(out_keep), 64'hFF);
      chk("w0_last", 64'(out_last), 64'h0);
      for (int i = 10; i <= 16; i++) send_byte(8'(i), 1'b0);
      step();
      chk("w1_valid", 64'(out_valid), 64'h1);
      chk("w1_data", out_data, 64'h100F0E0D0C0B0A09);
      chk("w1_keep", 64'(out_keep), 64'hFF);
      chk("w1_last", 64'(out_last), 64'h0);
      step();
      chk("w1_popped", 64'(out_valid), 64'h0);

      // Partial word closed by last_in.
      out_ready = 1'b0;
      send_byte(8'hA1, 1'b0);
      send_byte(8'hA2, 1'b0);
      send_byte(8'hA3, 1'b1);
      step();
      chk("part_data", out_data, {PAD, PAD, PAD, PAD, PAD, 8'hA3, 8'hA2, 8'hA1});
      chk("part_keep", 64'(out_keep), 64'h07);
      chk("part_last", 64'(out_last), 64'h1);
      chk("part_stable", out_data, {PAD, PAD, PAD, PAD, PAD, 8'hA3, 8'hA2, 8'hA1});
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("part_drained", 64'(fifo_cnt), 64'h0);

      // Fill the FIFO, then overflow with a fifth word.
      send_byte(8'hB0, 1'b1);
      send_byte(8'hB1, 1'b1);
      send_byte(8'hB2, 1'b1);
      chk("fill_cnt2", 64'(fifo_cnt), 64'h2);
      chk("fill_af_below", 64'(almost_full), 64'h0);
      send_byte(8'hB3, 1'b1);
      chk("fill_cnt3", 64'(fifo_cnt), 64'h3);
      chk("fill_af_at3", 64'(almost_full), 64'h1);
      send_byte(8'hB4, 1'b1);
      chk("fill_cnt4", 64'(fifo_cnt), 64'h4);
      chk("fill_ovf_clear", 64'(ovf_err), 64'h0);
      step();
      chk("ovf_set", 64'(ovf_err), 64'h1);
      chk("ovf_cnt4", 64'(fifo_cnt), 64'h4);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_data", out_data, {PAD, PAD, PAD, PAD, PAD, PAD, PAD, 8'(8'hB0 + i)});
         chk("drain_keep", 64'(out_keep), 64'h01);
         step();
      end
      chk("drain_empty", 64'(out_valid), 64'h0);
      chk("ovf_sticky", 64'(ovf_err), 64'h1);
      out_ready = 1'b0;

      // Full FIFO with the fifth word pushed in the same cycle as a pop.
      do_reset();
      chk("rst2_ovf", 64'(ovf_err), 64'h0);
      send_byte(8'hC0, 1'b1);
      send_byte(8'hC1, 1'b1);
      send_byte(8'hC2, 1'b1);
      send_byte(8'hC3, 1'b1);
      step();
      chk("full_cnt", 64'(fifo_cnt), 64'h4);
      send_byte(8'hC4, 1'b1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("pushpop_ovf", 64'(ovf_err), 64'h0);
      chk("pushpop_cnt", 64'(fifo_cnt), 64'h4);
      chk("pushpop_head", 64'(out_data[7:0]), 64'hC1);

      // Reset in the middle of a word with two words queued.
      out_ready = 1'b1;
      step();
      step();
      out_ready = 1'b0;
      chk("mid_cnt2", 64'(fifo_cnt), 64'h2);
      for (int i = 0; i < 5; i++) send_byte(8'(8'hD0 + i), 1'b0);
      do_reset();
      chk("mid_rst_valid", 64'(out_valid), 64'h0);
      chk("mid_rst_cnt", 64'(fifo_cnt), 64'h0);
      for (int i = 0; i < 8; i++) send_byte(8'(8'hE0 + i), 1'b0);
      step();
      chk("clean_cnt", 64'(fifo_cnt), 64'h1);
      chk("clean_data", out_data, 64'hE7E6E5E4E3E2E1E0);
      chk("clean_keep", 64'(out_keep), 64'hFF);
      chk("clean_last", 64'(out_last), 64'h0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // last_in on the eighth byte yields one full word and nothing after it.
      for (int i = 0; i < 7; i++) send_byte(8'(8'hF0 + i), 1'b0);
      send_byte(8'hF7, 1'b1);
      step();
      chk("l8_cnt", 64'(fifo_cnt), 64'h1);
      chk("l8_data", out_data, 64'hF7F6F5F4F3F2F1F0);
      chk("l8_keep", 64'(out_keep), 64'hFF);
      chk("l8_last", 64'(out_last), 64'h1);
      out_ready = 1'b1;
      step();
      step();
      step();
      chk("l8_no_trailer_valid", 64'(out_valid), 64'h0);
      chk("l8_no_trailer_cnt", 64'(fifo_cnt), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
